// File: rtl/wr_arria10_phy_pkg.sv
// Shared types and default timing constants for the Arria10 deterministic word-alignment control.
package wr_arria10_phy_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_RST       = 3'd1,
      ST_WAIT_LOCK = 3'd2,
      ST_ALIGN     = 3'd3,
      ST_WAIT_SYNC = 3'd4,
      ST_CHECK     = 3'd5,
      ST_LOCKED    = 3'd6,
      ST_FAIL      = 3'd7
   } det_state_e;

   typedef logic [19:0] slip_mask_t;

   localparam int unsigned c_DEF_RST_CYCLES   = 32;
   localparam int unsigned c_DEF_LOCK_TIMEOUT = 65535;
   localparam int unsigned c_DEF_ALIGN_TIMEOUT = 4095;
   localparam int unsigned c_DEF_LOS_CYCLES   = 16;
   localparam int unsigned c_DEF_MAX_RETRIES  = 15;

   function automatic int unsigned max_of4(input int unsigned a, input int unsigned b,
                                           input int unsigned c, input int unsigned d);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/wr_det_timeout_cnt.sv
// Loadable saturating down-counter; expired_c is high while the count sits at zero.
module wr_det_timeout_cnt #(
   parameter int unsigned g_WIDTH = 17
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic [g_WIDTH-1:0] value,
   input  logic               dec,
   output logic               expired_c
);

   logic [g_WIDTH-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= value;
      end else if (dec && (count != '0)) begin
         count <= count - g_WIDTH'(1);
      end
   end

   assign expired_c = (count == '0);

endmodule

// File: rtl/wr_arria10_det_align_ctrl.sv
// Sequences PHY RX reset, CDR lock, word alignment and bitslip acceptance, with bounded retries.
module wr_arria10_det_align_ctrl
   import wr_arria10_phy_pkg::*;
#(
   parameter int unsigned g_BYTES         = 1,
   parameter int unsigned g_RST_CYCLES    = c_DEF_RST_CYCLES,
   parameter int unsigned g_LOCK_TIMEOUT  = c_DEF_LOCK_TIMEOUT,
   parameter int unsigned g_ALIGN_TIMEOUT = c_DEF_ALIGN_TIMEOUT,
   parameter int unsigned g_LOS_CYCLES    = c_DEF_LOS_CYCLES,
   parameter int unsigned g_MAX_RETRIES   = c_DEF_MAX_RETRIES,
   parameter slip_mask_t  g_SLIP_MASK     = 20'h00001
) (
   input  logic               clk_rx_i,
   input  logic               rst_n_i,
   input  logic               enable_i,
   input  logic               rx_is_lockedtodata_i,
   input  logic [g_BYTES-1:0] rx_syncstatus_i,
   input  logic [4:0]         rx_bitslipboundarysel_i,
   output logic               rx_digitalreset_o,
   output logic               rx_patternalign_o,
   output logic               ready_o,
   output logic               fail_o,
   output logic [4:0]         bitslip_o,
   output logic [3:0]         retries_o,
   output logic [2:0]         state_o
);

   localparam int unsigned c_TO_MAX = max_of4(g_RST_CYCLES, g_LOCK_TIMEOUT, g_ALIGN_TIMEOUT, g_LOS_CYCLES);
   localparam int unsigned c_TW     = $clog2(c_TO_MAX) + 1;
   localparam int unsigned c_SYM_W  = 10 * g_BYTES;

   // Counter is loaded with N-1 so the state is left on the N-th cycle spent in it.
   localparam logic [c_TW-1:0] c_RST_LOAD   = c_TW'(g_RST_CYCLES - 1);
   localparam logic [c_TW-1:0] c_LOCK_LOAD  = c_TW'(g_LOCK_TIMEOUT - 1);
   localparam logic [c_TW-1:0] c_ALIGN_LOAD = c_TW'(g_ALIGN_TIMEOUT - 1);
   localparam logic [c_TW-1:0] c_LOS_LOAD   = c_TW'(g_LOS_CYCLES - 1);
   localparam logic [3:0]      c_MAX_RT     = 4'(g_MAX_RETRIES);
   localparam logic [31:0]     c_MASK_EXT   = 32'(g_SLIP_MASK);

   logic [1:0]      rst_sync;
   logic            rst_n;
   det_state_e      state;
   det_state_e      state_nx;
   logic [3:0]      retries_nx;
   logic [4:0]      bitslip_nx;
   logic            tmr_load;
   logic [c_TW-1:0] tmr_value;
   logic            tmr_dec;
   logic            tmr_expired;
   logic            retry;
   logic            sync_all;
   logic            slip_ok;

   // Asynchronous assertion, release aligned to clk_rx_i.
   always_ff @(posedge clk_rx_i or negedge rst_n_i) begin
      if (!rst_n_i) rst_sync <= 2'b00;
      else          rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_n = rst_sync[1];

   assign sync_all = &rx_syncstatus_i;
   assign slip_ok  = (32'(rx_bitslipboundarysel_i) < c_SYM_W) && c_MASK_EXT[rx_bitslipboundarysel_i];

   wr_det_timeout_cnt #(.g_WIDTH(c_TW)) u_timeout (
      .clk       (clk_rx_i),
      .rst_n     (rst_n),
      .load      (tmr_load),
      .value     (tmr_value),
      .dec       (tmr_dec),
      .expired_c (tmr_expired)
   );

   always_ff @(posedge clk_rx_i or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx   = state;
      retries_nx = retries_o;
      bitslip_nx = bitslip_o;
      tmr_load   = 1'b0;
      tmr_value  = '0;
      tmr_dec    = 1'b0;
      retry      = 1'b0;
      if (!enable_i) begin
         state_nx   = ST_IDLE;
         retries_nx = '0;
      end else begin
         // Success conditions are tested before the timeout in every waiting state.
         case (state)
            ST_IDLE: begin
               state_nx  = ST_RST;
               tmr_load  = 1'b1;
               tmr_value = c_RST_LOAD;
            end
            ST_RST: begin
               if (tmr_expired) begin
                  state_nx  = ST_WAIT_LOCK;
                  tmr_load  = 1'b1;
                  tmr_value = c_LOCK_LOAD;
               end else begin
                  tmr_dec = 1'b1;
               end
            end
            ST_WAIT_LOCK: begin
               if (rx_is_lockedtodata_i) state_nx = ST_ALIGN;
               else if (tmr_expired)     retry    = 1'b1;
               else                      tmr_dec  = 1'b1;
            end
            ST_ALIGN: begin
               state_nx  = ST_WAIT_SYNC;
               tmr_load  = 1'b1;
               tmr_value = c_ALIGN_LOAD;
            end
            ST_WAIT_SYNC: begin
               if (sync_all)         state_nx = ST_CHECK;
               else if (tmr_expired) retry    = 1'b1;
               else                  tmr_dec  = 1'b1;
            end
            ST_CHECK: begin
               if (slip_ok) begin
                  state_nx   = ST_LOCKED;
                  bitslip_nx = rx_bitslipboundarysel_i;
                  retries_nx = '0;
                  tmr_load   = 1'b1;
                  tmr_value  = c_LOS_LOAD;
               end else begin
                  retry = 1'b1;
               end
            end
            ST_LOCKED: begin
               if (!rx_is_lockedtodata_i) begin
                  retry = 1'b1;
               end else if (sync_all) begin
                  tmr_load  = 1'b1;
                  tmr_value = c_LOS_LOAD;
               end else if (tmr_expired) begin
                  retry = 1'b1;
               end else begin
                  tmr_dec = 1'b1;
               end
            end
            ST_FAIL: state_nx = ST_FAIL;
         endcase
         if (retry) begin
            if (retries_o == c_MAX_RT) begin
               state_nx = ST_FAIL;
            end else begin
               state_nx   = ST_RST;
               retries_nx = (retries_o == 4'hF) ? retries_o : retries_o + 4'd1;
               tmr_load   = 1'b1;
               tmr_value  = c_RST_LOAD;
            end
         end
      end
   end

   // Outputs are registered decodes of the next state so they change with the state register.
   always_ff @(posedge clk_rx_i or negedge rst_n) begin
      if (!rst_n) begin
         rx_digitalreset_o <= 1'b1;
         rx_patternalign_o <= 1'b0;
         ready_o           <= 1'b0;
         fail_o            <= 1'b0;
         bitslip_o         <= '0;
         retries_o         <= '0;
      end else begin
         rx_digitalreset_o <= (state_nx == ST_IDLE) || (state_nx == ST_RST) || (state_nx == ST_FAIL);
         rx_patternalign_o <= (state_nx == ST_ALIGN);
         ready_o           <= (state_nx == ST_LOCKED);
         fail_o            <= (state_nx == ST_FAIL);
         bitslip_o         <= bitslip_nx;
         retries_o         <= retries_nx;
      end
   end

   assign state_o = state;

endmodule

// File: doc/wr_arria10_det_align_ctrl.md
WR_ARRIA10_DET_ALIGN_CTRL -- requirements
Module: wr_arria10_det_align_ctrl

Interface
REQ-001 SHALL have parameter g_BYTES, default 1, meaning PHY parallel width in bytes (1 or 2); symbol width is 10*g_BYTES bits.
REQ-002 SHALL have parameter g_RST_CYCLES, default 32, meaning the rx_digitalreset assertion length.
REQ-003 SHALL have parameter g_LOCK_TIMEOUT, default 65535, meaning the maximum number of cycles to wait for CDR lock-to-data.
REQ-004 SHALL have parameter g_ALIGN_TIMEOUT, default 4095, meaning the maximum number of cycles to wait for syncstatus after the align request.
REQ-005 SHALL have parameter g_LOS_CYCLES, default 16, meaning consecutive syncstatus-low cycles that declare loss of sync.
REQ-006 SHALL have parameter g_MAX_RETRIES, default 15, meaning the number of realignment attempts before FAIL.
REQ-007 SHALL have parameter g_SLIP_MASK, default 20'h00001, meaning set bit n accepts a bitslip value of n.
REQ-008 clk_rx_i  in  1  rx_clkout domain clock; all logic is single-clock.
REQ-009 rst_n_i  in  1  reset, asynchronous, active-low.
REQ-010 enable_i  in  1  start/hold alignment; low forces IDLE.
REQ-011 rx_is_lockedtodata_i  in  1  CDR locked-to-data, already synchronised to clk_rx_i.
REQ-012 rx_syncstatus_i  in  g_BYTES  word-aligner sync per byte.
REQ-013 rx_bitslipboundarysel_i  in  5  aligner bitslip count.
REQ-014 rx_digitalreset_o  out  1  PHY RX digital reset request.
REQ-015 rx_patternalign_o  out  1  one-cycle word-align request pulse.
REQ-016 ready_o  out  1  link aligned with an accepted bitslip.
REQ-017 fail_o  out  1  retries exhausted.
REQ-018 bitslip_o  out  5  bitslip latched at acceptance, for link-delay compensation.
REQ-019 retries_o  out  4  attempts since the last enable rise or since LOCKED.
REQ-020 state_o  out  3  FSM state encoding, for debug.

Function
REQ-021 The FSM SHALL implement the states IDLE, RST, WAIT_LOCK, ALIGN, WAIT_SYNC, CHECK, LOCKED and FAIL.
REQ-022 IDLE SHALL hold rx_digitalreset_o=1 and move to RST on the cycle enable_i=1 is sampled.
REQ-023 RST SHALL assert rx_digitalreset_o for exactly g_RST_CYCLES cycles, then move to WAIT_LOCK with the reset released.
REQ-024 WAIT_LOCK SHALL go to ALIGN on the first cycle rx_is_lockedtodata_i=1; after g_LOCK_TIMEOUT cycles without lock it SHALL be treated as a retry.
REQ-025 ALIGN SHALL drive rx_patternalign_o=1 for exactly one cycle, then go to WAIT_SYNC.
REQ-026 WAIT_SYNC SHALL go to CHECK when all g_BYTES syncstatus bits are 1; after g_ALIGN_TIMEOUT cycles without sync it SHALL be treated as a retry.
REQ-027 CHECK SHALL take one cycle: if g_SLIP_MASK[bitslip] is set and bitslip < 10*g_BYTES, it SHALL latch bitslip_o, clear retries_o and go to LOCKED; otherwise it SHALL be treated as a retry.
REQ-028 A retry SHALL increment retries_o and go to RST; if retries_o already equals g_MAX_RETRIES, it SHALL go to FAIL without incrementing.
REQ-029 LOCKED SHALL hold ready_o=1; loss of lockedtodata (1 cycle) or any syncstatus low for g_LOS_CYCLES consecutive cycles SHALL deassert ready_o the next cycle and count as a retry.
REQ-030 FAIL SHALL hold fail_o=1 and rx_digitalreset_o=1 until enable_i=0.
REQ-031 enable_i=0 in any state SHALL force IDLE on the next cycle, clear ready_o, fail_o and retries_o, and keep bitslip_o.
REQ-032 When a timeout and a success condition occur in the same cycle, success SHALL win.
REQ-033 Counters SHALL saturate and never wrap; the timeout counter width SHALL be $clog2 of the largest timeout plus 1.

Reset
REQ-034 On rst_n_i=0 the block SHALL asynchronously enter IDLE with rx_digitalreset_o=1, all other outputs 0, and all counters 0.
REQ-035 Reset release SHALL be synchronous to clk_rx_i; the first transition SHALL occur no earlier than the first edge after release.

Structure
REQ-036 The state encoding, the 20-bit slip-mask type and the default timeout constants SHALL live in a shared package, wr_arria10_phy_pkg.
REQ-037 One sub-module, wr_det_timeout_cnt (a loadable saturating down-counter with an expired flag), SHALL be instantiated for the reset, lock, align and LOS timing.

Verification
REQ-038 Scenario 1: enable=1, lock after 100 cycles, sync 50 cycles after the align pulse, bitslip=0 -> ready_o=1 within RST+100+1+50+2 cycles, bitslip_o=0, retries_o=0.
REQ-039 Scenario 2: bitslip sequence 3,7,0 -> two retries, rx_digitalreset_o pulsed 3 times total, ready_o=1 with bitslip_o=0.
REQ-040 Scenario 3: lock never asserted, g_LOCK_TIMEOUT=100, g_MAX_RETRIES=2 -> fail_o=1 after 3 timeouts, reset held; enable=0 -> IDLE with fail_o=0.
REQ-041 Scenario 4: in LOCKED, syncstatus low for 15 cycles -> ready_o stays 1; low for 16 cycles -> ready_o=0, RST entered, retries_o=1.
REQ-042 Scenario 5: g_BYTES=2, only syncstatus[0]=1 -> no CHECK until both bits are 1.
REQ-043 Scenario 6: rst_n_i asserted mid-WAIT_SYNC -> same-cycle IDLE and reset values, no patternalign pulse.
